// File: rtl/dmem_pkg.sv
// Shared widths and port identifiers for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 8;
    localparam int unsigned DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_CPU  = 2'd1,
        PORT_HOST = 2'd2
    } port_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory signals of the data-memory arbiter, grouped as one bundle.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic                   cpu_req;
    logic                   cpu_wr;
    logic [DMEM_ADDR_W-1:0] cpu_addr;
    logic [DMEM_DATA_W-1:0] cpu_wdata;
    logic                   cpu_gnt;
    logic                   cpu_rvalid;
    logic [DMEM_DATA_W-1:0] cpu_rdata;

    logic                   host_req;
    logic                   host_wr;
    logic [DMEM_ADDR_W-1:0] host_addr;
    logic [DMEM_DATA_W-1:0] host_wdata;
    logic                   host_gnt;
    logic                   host_rvalid;
    logic [DMEM_DATA_W-1:0] host_rdata;

    logic [DMEM_ADDR_W-1:0] mem_addr;
    logic                   mem_wr;
    logic [DMEM_DATA_W-1:0] mem_wdata;
    logic [DMEM_DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  host_req, host_wr, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output host_req, host_wr, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / host) data-memory arbiter: CPU priority with a host starvation
// bound, combinational grant and memory mux, one-cycle pipelined read-valid.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic           Clock,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    port_t            rd_port;
    port_t            rd_port_nxt;
    port_t            grant_c;
    logic             host_due_c;

    // State registers: starvation counter and the single in-flight read record.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve_cnt <= '0;
            rd_port    <= PORT_NONE;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            rd_port    <= rd_port_nxt;
        end
    end

    // Grant decision and next-state; Reset forces every grant and access off.
    always_comb begin
        grant_c        = PORT_NONE;
        rd_port_nxt    = PORT_NONE;
        starve_cnt_nxt = '0;
        host_due_c     = (starve_cnt == CNT_W'(STARVE_LIMIT));

        if (!Reset) begin
            if (bus.host_req && (!bus.cpu_req || host_due_c)) begin
                grant_c = PORT_HOST;
            end else if (bus.cpu_req) begin
                grant_c = PORT_CPU;
            end

            if ((grant_c == PORT_CPU && !bus.cpu_wr) ||
                (grant_c == PORT_HOST && !bus.host_wr)) begin
                rd_port_nxt = grant_c;
            end

            if (bus.host_req && grant_c != PORT_HOST) begin
                starve_cnt_nxt = host_due_c ? starve_cnt : starve_cnt + CNT_W'(1);
            end
        end
    end

    // Memory-side mux: only the granted port reaches the memory, else all zero.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;
        unique case (grant_c)
            PORT_CPU: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wr    = bus.cpu_wr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            PORT_HOST: begin
                bus.mem_addr  = bus.host_addr;
                bus.mem_wr    = bus.host_wr;
                bus.mem_wdata = bus.host_wdata;
            end
            default: ;
        endcase
    end

    assign bus.cpu_gnt  = (grant_c == PORT_CPU);
    assign bus.host_gnt = (grant_c == PORT_HOST);

    // Gated by Reset so a read granted just before reset never reports valid.
    assign bus.cpu_rvalid  = !Reset && (rd_port == PORT_CPU);
    assign bus.host_rvalid = !Reset && (rd_port == PORT_HOST);

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.host_rdata = bus.mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: number of consecutive cycles host may wait before forced grant.
REQ-002 Clock  input  1  system clock; reset Reset, synchronous, active-high; clock Clock.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 cpu_req  input  1  CPU datapath requests data memory access.
REQ-005 cpu_wr  input  1  1 = write, 0 = read.
REQ-006 cpu_addr  input  8  CPU data memory address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-009 cpu_rvalid  output  1  CPU read data valid.
REQ-010 cpu_rdata  output  16  CPU read data.
REQ-011 host_req, host_wr, host_addr[8], host_wdata[16]  inputs  host/debug loader port; same meaning as the CPU inputs.
REQ-012 host_gnt, host_rvalid, host_rdata[16]  outputs  host port; same meaning as the CPU outputs.
REQ-013 mem_addr  output  8  data memory address.
REQ-014 mem_wr  output  1  data memory write enable.
REQ-015 mem_wdata  output  16  data memory write data.
REQ-016 mem_rdata  input  16  data memory read data, synchronous, valid 1 cycle after address.

Function
REQ-017 Arbitration SHALL be combinational within a cycle: at most one of cpu_gnt/host_gnt is high per cycle, and gnt is high only while the matching req is high.
REQ-018 Default priority SHALL be CPU; host wins only when cpu_req=0 or the starvation counter equals STARVE_LIMIT.
REQ-019 Starvation counter SHALL increment each cycle host_req=1 without host_gnt, SHALL saturate at STARVE_LIMIT, and SHALL clear on host_gnt or host_req=0.
REQ-020 mem_addr/mem_wr/mem_wdata SHALL follow the granted port; with no grant they SHALL be 0.
REQ-021 Writes from an ungranted port SHALL never reach memory.
REQ-022 Requesters SHALL hold req/wr/addr/wdata until gnt; dropping req before gnt SHALL be legal and cause no access.
REQ-023 A granted read SHALL assert that port's rvalid for exactly one cycle, in the cycle after the grant; a write SHALL assert no rvalid.
REQ-024 cpu_rdata and host_rdata SHALL equal mem_rdata; contents are meaningful only while the matching rvalid is high.
REQ-025 Back-to-back grants (any port, any cycle) SHALL be supported with a fully pipelined rvalid, one read in flight per cycle.

Reset
REQ-026 While Reset=1: both gnt outputs, both rvalid outputs, mem_wr, mem_addr and mem_wdata SHALL be 0, and the starvation counter SHALL be 0.
REQ-027 A read granted in the cycle before Reset SHALL NOT produce rvalid.

Structure
REQ-028 Package dmem_pkg SHALL hold DMEM_ADDR_W=8, DMEM_DATA_W=16, and the enum port_t {PORT_NONE, PORT_CPU, PORT_HOST}.
REQ-029 The block SHALL be a single module with no sub-module; the in-flight read record SHALL be one registered port_t.

Verification
REQ-030 Reset, then cpu write 0x10/0xBEEF -> cpu_gnt same cycle, mem_wr=1, mem_addr=0x10, mem_wdata=0xBEEF; next cycle, cpu read 0x10 -> cpu_rvalid high the cycle after, cpu_rdata=0xBEEF.
REQ-031 Both ports request continuously, STARVE_LIMIT=3 -> grants CPU, CPU, CPU, HOST, repeating with period 4.
REQ-032 Host-only read 0x20 -> host_gnt same cycle, host_rvalid next cycle, cpu_rvalid stays 0.
REQ-033 Reset asserted the cycle after a cpu read grant -> cpu_rvalid 0, all outputs 0, counter 0.
REQ-034 Host write 0xFF/0x1234 held while the CPU wins -> mem_wr never drives address 0xFF until host_gnt, and memory at 0xFF is unchanged before then.
